// File: rtl/fifo_uart_tx.sv
// Drain side of the byte FIFO: fetches each pending byte and shifts it out as an async serial frame.
// Define FIFO_UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module fifo_uart_tx #(
   parameter int DATA_WIDTH = 8,
   parameter int UP_BIT     = 4,
   parameter int CLK_DIV    = 16,
   parameter int DIV_BIT    = 16
) (
   input  logic                  i_clk,
   input  logic                  i_rest_n,
   input  logic                  i_tx_en,
   input  logic [UP_BIT-1:0]     i_addrw,
   input  logic [UP_BIT-1:0]     i_addrr,
   input  logic [DATA_WIDTH-1:0] i_data,
   output logic                  o_ren,
   output logic                  o_txd,
   output logic                  o_busy
);

   localparam int CNT_W = $clog2(DATA_WIDTH + 1);

`ifdef FIFO_UART_TX_PARITY_EN
   typedef enum logic [2:0] {IDLE, FETCH, WAIT, START, DATA, PARITY, STOP} state_t;
`else
   typedef enum logic [2:0] {IDLE, FETCH, WAIT, START, DATA, STOP} state_t;
`endif

   state_t                state, state_next;
   logic [DIV_BIT-1:0]    div_cnt, div_next;
   logic [CNT_W-1:0]      bit_cnt, bit_next;
   logic [DATA_WIDTH-1:0] shift_reg, shift_next;
   logic                  ren_next, txd_next, busy_next;
   logic                  fifo_not_empty, bit_end, last_bit;
`ifdef FIFO_UART_TX_PARITY_EN
   logic                  parity_reg, parity_next;
`endif

   assign fifo_not_empty = (i_addrw != i_addrr);
   assign bit_end        = (div_cnt == DIV_BIT'(CLK_DIV - 1));
   assign last_bit       = (bit_cnt == CNT_W'(DATA_WIDTH - 1));

   always_ff @(posedge i_clk or negedge i_rest_n) begin
      if (!i_rest_n) begin
         state      <= IDLE;
         div_cnt    <= '0;
         bit_cnt    <= '0;
         shift_reg  <= '0;
         o_ren      <= 1'b0;
         o_txd      <= 1'b1;
         o_busy     <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
         parity_reg <= 1'b0;
`endif
      end else begin
         state      <= state_next;
         div_cnt    <= div_next;
         bit_cnt    <= bit_next;
         shift_reg  <= shift_next;
         o_ren      <= ren_next;
         o_txd      <= txd_next;
         o_busy     <= busy_next;
`ifdef FIFO_UART_TX_PARITY_EN
         parity_reg <= parity_next;
`endif
      end
   end

   // Outputs are registered from the next-state view, so each tracks the state it belongs to.
   always_comb begin
      state_next  = state;
      div_next    = bit_end ? '0 : div_cnt + DIV_BIT'(1);
      bit_next    = bit_cnt;
      shift_next  = shift_reg;
`ifdef FIFO_UART_TX_PARITY_EN
      parity_next = parity_reg;
`endif
      case (state)
         IDLE: begin
            div_next = '0;
            if (i_tx_en && fifo_not_empty) state_next = FETCH;
         end
         FETCH: begin
            div_next   = '0;
            state_next = WAIT;
         end
         WAIT: begin
            div_next    = '0;
            bit_next    = '0;
            shift_next  = i_data;
`ifdef FIFO_UART_TX_PARITY_EN
            parity_next = ^i_data;
`endif
            state_next  = START;
         end
         START: begin
            if (bit_end) state_next = DATA;
         end
         DATA: begin
            if (bit_end) begin
               shift_next = shift_reg >> 1;
               bit_next   = bit_cnt + CNT_W'(1);
`ifdef FIFO_UART_TX_PARITY_EN
               if (last_bit) state_next = PARITY;
`else
               if (last_bit) state_next = STOP;
`endif
            end
         end
`ifdef FIFO_UART_TX_PARITY_EN
         PARITY: begin
            if (bit_end) state_next = STOP;
         end
`endif
         STOP: begin
            if (bit_end) state_next = (i_tx_en && fifo_not_empty) ? FETCH : IDLE;
         end
         default: state_next = IDLE;
      endcase

      ren_next  = (state_next == FETCH);
      busy_next = (state_next != IDLE);
      case (state_next)
         START:   txd_next = 1'b0;
         DATA:    txd_next = shift_next[0];
`ifdef FIFO_UART_TX_PARITY_EN
         PARITY:  txd_next = parity_next;
`endif
         default: txd_next = 1'b1;
      endcase
   end

endmodule
